// File: rtl/stage_ctrl_pkg.sv
// Shared opcode and state constants for the Pillar core control sequencer,
// plus small opcode classification helpers used by the controller.
package stage_ctrl_pkg;

    localparam logic [6:0] DECODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] DECODE_I_TYPE = 7'b0010011;
    localparam logic [6:0] DECODE_L_TYPE = 7'b0000011;
    localparam logic [6:0] DECODE_S_TYPE = 7'b0100011;

    typedef enum logic [2:0] {
        STATE_IDLE   = 3'd0,
        STATE_FETCH  = 3'd1,
        STATE_DECODE = 3'd2,
        STATE_EXEC   = 3'd3,
        STATE_MEM    = 3'd4,
        STATE_WB     = 3'd5,
        STATE_HALT   = 3'd6
    } state_t;

    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == DECODE_L_TYPE) || (op == DECODE_S_TYPE);
    endfunction

    // Instructions whose result goes through the write stage (R, I, L).
    function automatic logic op_writes_rd(input logic [6:0] op);
        return (op == DECODE_R_TYPE) || (op == DECODE_I_TYPE) || (op == DECODE_L_TYPE);
    endfunction

    function automatic logic op_is_legal(input logic [6:0] op);
        return op_writes_rd(op) || (op == DECODE_S_TYPE);
    endfunction

endpackage

// File: rtl/stage_ctrl_if.sv
// Control bundle between the stage sequencer (master) and the datapath (slave).
interface stage_ctrl_if;

    logic        run_i;
    logic [31:0] ir_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;
    logic        fetch_req_o;
    logic        ir_load_o;
    logic        alu_en_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        wd_q_readin_o;
    logic        rf_we_o;
    logic        pc_load_o;
    logic [2:0]  state_o;
    logic [31:0] retired_o;
    logic        fault_o;

    modport master (
        input  run_i, ir_i, imem_ready_i, dmem_ready_i,
        output fetch_req_o, ir_load_o, alu_en_o, dmem_req_o, dmem_we_o,
               wd_q_readin_o, rf_we_o, pc_load_o, state_o, retired_o, fault_o
    );

    modport slave (
        output run_i, ir_i, imem_ready_i, dmem_ready_i,
        input  fetch_req_o, ir_load_o, alu_en_o, dmem_req_o, dmem_we_o,
               wd_q_readin_o, rf_we_o, pc_load_o, state_o, retired_o, fault_o
    );

endinterface

// File: rtl/stage_ctrl_wait_timer.sv
// 8-bit clear/increment counter; 'last' flags that the next increment
// reaches LIMIT, so the caller can act in the same cycle.
module stage_ctrl_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [7:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= 8'd0;
        end else if (inc) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign last = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/stage_ctrl.sv
// Multi-cycle control sequencer: walks one instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
module stage_ctrl
    import stage_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    stage_ctrl_if.master  bus
);

    state_t      state_q, state_d;
    logic        fault_q, fault_d;
    logic [31:0] retired_q;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        unused_ir;
    logic        timer_clr, timer_inc, timer_last;

    assign opcode    = bus.ir_i[6:0];
    assign rd        = bus.ir_i[11:7];
    assign unused_ir = ^bus.ir_i[31:12];

    stage_ctrl_wait_timer #(.LIMIT(MEM_WAIT_MAX)) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .inc   (timer_inc),
        .last  (timer_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STATE_IDLE;
            fault_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == STATE_WB) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case can leave a variable unassigned and infer a latch.
        state_d           = state_q;
        fault_d           = fault_q;
        timer_clr         = 1'b0;
        timer_inc         = 1'b0;
        bus.fetch_req_o   = 1'b0;
        bus.ir_load_o     = 1'b0;
        bus.alu_en_o      = 1'b0;
        bus.dmem_req_o    = 1'b0;
        bus.dmem_we_o     = 1'b0;
        bus.wd_q_readin_o = 1'b0;
        bus.rf_we_o       = 1'b0;
        bus.pc_load_o     = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (bus.run_i) state_d = STATE_FETCH;
            end
            STATE_FETCH: begin
                bus.fetch_req_o = 1'b1;
                bus.ir_load_o   = bus.imem_ready_i;
                if (bus.imem_ready_i) state_d = STATE_DECODE;
            end
            STATE_DECODE: begin
                if (op_is_legal(opcode)) begin
                    state_d = STATE_EXEC;
                end else begin
                    state_d = STATE_HALT;
                    fault_d = 1'b1;
                end
            end
            STATE_EXEC: begin
                bus.alu_en_o = 1'b1;
                timer_clr    = 1'b1;
                state_d      = op_is_mem(opcode) ? STATE_MEM : STATE_WB;
            end
            STATE_MEM: begin
                bus.dmem_req_o = 1'b1;
                bus.dmem_we_o  = (opcode == DECODE_S_TYPE);
                // A ready arriving on the limit cycle still completes the access.
                if (bus.dmem_ready_i) begin
                    state_d = STATE_WB;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_last) begin
                        state_d = STATE_HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            STATE_WB: begin
                bus.pc_load_o     = 1'b1;
                bus.wd_q_readin_o = op_writes_rd(opcode);
                bus.rf_we_o       = op_writes_rd(opcode) && (rd != 5'd0);
                state_d           = bus.run_i ? STATE_FETCH : STATE_IDLE;
            end
            STATE_HALT: begin
                state_d = STATE_HALT;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    assign bus.state_o   = state_q;
    assign bus.retired_o = retired_q;
    assign bus.fault_o   = fault_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// Directed bench for stage_ctrl: steps hand-built instructions through the
// sequencer and compares state, strobes, retired count and fault flag.
module tb_stage_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stage_ctrl_if sif ();

    stage_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] INSN_ADD  = 32'h002081B3;
    localparam logic [31:0] INSN_LW   = 32'h0000A283;
    localparam logic [31:0] INSN_SW   = 32'h0020A023;
    localparam logic [31:0] INSN_NOP  = 32'h00000013;
    localparam logic [31:0] INSN_ILL  = 32'h0000007F;

    // Strobe vector order: fetch, ir_load, alu, dmem_req, dmem_we, wd, rf_we, pc_load
    localparam logic [7:0] SB_NONE   = 8'b0000_0000;
    localparam logic [7:0] SB_FETCH  = 8'b1000_0000;
    localparam logic [7:0] SB_FETCHL = 8'b1100_0000;
    localparam logic [7:0] SB_EXEC   = 8'b0010_0000;
    localparam logic [7:0] SB_MEMRD  = 8'b0001_0000;
    localparam logic [7:0] SB_MEMWR  = 8'b0001_1000;
    localparam logic [7:0] SB_WBRD   = 8'b0000_0111;
    localparam logic [7:0] SB_WBX0   = 8'b0000_0101;
    localparam logic [7:0] SB_WBST   = 8'b0000_0001;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [2:0] st, input logic [7:0] sb);
        logic [7:0] observed_sb;
        observed_sb = {sif.fetch_req_o, sif.ir_load_o, sif.alu_en_o, sif.dmem_req_o,
                       sif.dmem_we_o, sif.wd_q_readin_o, sif.rf_we_o, sif.pc_load_o};
        check({tag, ".state"}, 32'(sif.state_o), 32'(st));
        check({tag, ".strobes"}, 32'(observed_sb), 32'(sb));
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        sif.run_i        = 1'b0;
        sif.ir_i         = 32'd0;
        sif.imem_ready_i = 1'b0;
        sif.dmem_ready_i = 1'b0;
        tick();
        tick();

        // Reset state
        check_cycle("reset", 3'd0, SB_NONE);
        check("reset.retired", sif.retired_o, 32'd0);
        check("reset.fault", 32'(sif.fault_o), 32'd0);

        // add x3,x1,x2 with zero-wait memories
        reset = 1'b0;
        sif.run_i = 1'b1; sif.imem_ready_i = 1'b1; sif.dmem_ready_i = 1'b1;
        sif.ir_i = INSN_ADD;
        tick(); check_cycle("add.fetch", 3'd1, SB_FETCHL);
        tick(); check_cycle("add.decode", 3'd2, SB_NONE);
        tick(); check_cycle("add.exec", 3'd3, SB_EXEC);
        tick(); check_cycle("add.wb", 3'd5, SB_WBRD);
        check("add.wb.retired", sif.retired_o, 32'd0);
        tick(); check_cycle("add.next", 3'd1, SB_FETCHL);
        check("add.retired", sif.retired_o, 32'd1);

        // lw x5,0(x1): ready arrives on the 3rd MEM cycle
        sif.ir_i = INSN_LW; sif.dmem_ready_i = 1'b0;
        tick(); check_cycle("lw.decode", 3'd2, SB_NONE);
        tick(); check_cycle("lw.exec", 3'd3, SB_EXEC);
        tick(); check_cycle("lw.mem1", 3'd4, SB_MEMRD);
        tick(); check_cycle("lw.mem2", 3'd4, SB_MEMRD);
        tick(); sif.dmem_ready_i = 1'b1; settle();
        check_cycle("lw.mem3", 3'd4, SB_MEMRD);
        tick(); check_cycle("lw.wb", 3'd5, SB_WBRD);
        tick(); check_cycle("lw.next", 3'd1, SB_FETCHL);
        check("lw.retired", sif.retired_o, 32'd2);

        // sw x2,0(x1), then run_i low during WB returns to IDLE
        sif.ir_i = INSN_SW;
        tick(); check_cycle("sw.decode", 3'd2, SB_NONE);
        tick(); check_cycle("sw.exec", 3'd3, SB_EXEC);
        tick(); check_cycle("sw.mem", 3'd4, SB_MEMWR);
        tick(); sif.run_i = 1'b0; settle();
        check_cycle("sw.wb", 3'd5, SB_WBST);
        tick(); check_cycle("sw.idle", 3'd0, SB_NONE);
        check("sw.retired", sif.retired_o, 32'd3);

        // Ready inputs in IDLE are ignored
        tick(); check_cycle("idle.ready_ignored", 3'd0, SB_NONE);

        // addi x0,x0,0 with run_i dropped mid-instruction
        sif.ir_i = INSN_NOP; sif.run_i = 1'b1;
        tick(); check_cycle("nop.fetch", 3'd1, SB_FETCHL);
        tick(); sif.run_i = 1'b0; settle();
        check_cycle("nop.decode", 3'd2, SB_NONE);
        tick(); check_cycle("nop.exec", 3'd3, SB_EXEC);
        tick(); check_cycle("nop.wb", 3'd5, SB_WBX0);
        tick(); check_cycle("nop.idle", 3'd0, SB_NONE);
        check("nop.retired", sif.retired_o, 32'd4);

        // Retired counter wrap, with a fetch that waits on imem_ready_i
        force dut.retired_q = 32'hFFFF_FFFF;
        settle();
        release dut.retired_q;
        settle();
        check("wrap.preload", sif.retired_o, 32'hFFFF_FFFF);
        sif.ir_i = INSN_ADD; sif.imem_ready_i = 1'b0; sif.run_i = 1'b1;
        tick(); check_cycle("wrap.fetch_wait1", 3'd1, SB_FETCH);
        tick(); check_cycle("wrap.fetch_wait2", 3'd1, SB_FETCH);
        sif.imem_ready_i = 1'b1; settle();
        check_cycle("wrap.fetch_ready", 3'd1, SB_FETCHL);
        tick(); sif.run_i = 1'b0; settle();
        check_cycle("wrap.decode", 3'd2, SB_NONE);
        tick(); tick(); check_cycle("wrap.wb", 3'd5, SB_WBRD);
        check("wrap.wb.retired", sif.retired_o, 32'hFFFF_FFFF);
        tick(); check_cycle("wrap.idle", 3'd0, SB_NONE);
        check("wrap.retired", sif.retired_o, 32'd0);

        // Reset sampled in the 2nd MEM cycle of a load
        sif.ir_i = INSN_LW; sif.dmem_ready_i = 1'b0; sif.run_i = 1'b1;
        tick(); tick(); tick(); tick();
        check_cycle("rst_mem.mem1", 3'd4, SB_MEMRD);
        tick(); reset = 1'b1; settle();
        check_cycle("rst_mem.mem2", 3'd4, SB_MEMRD);
        tick(); check_cycle("rst_mem.after", 3'd0, SB_NONE);
        check("rst_mem.fault", 32'(sif.fault_o), 32'd0);
        reset = 1'b0;

        // Load whose data memory never answers: HALT after 15 MEM cycles
        tick(); tick(); tick(); tick();
        check_cycle("tmo.mem1", 3'd4, SB_MEMRD);
        for (int i = 2; i <= 15; i++) begin
            tick();
            check(i == 15 ? "tmo.mem15.state" : "tmo.memN.state", 32'(sif.state_o), 32'd4);
        end
        check("tmo.mem15.fault", 32'(sif.fault_o), 32'd0);
        tick(); check_cycle("tmo.halt", 3'd6, SB_NONE);
        check("tmo.fault", 32'(sif.fault_o), 32'd1);
        sif.dmem_ready_i = 1'b1;
        tick(); check_cycle("tmo.halt_hold", 3'd6, SB_NONE);

        // Illegal opcode after a reset out of HALT
        reset = 1'b1;
        tick();
        check_cycle("ill.reset", 3'd0, SB_NONE);
        check("ill.reset.fault", 32'(sif.fault_o), 32'd0);
        reset = 1'b0; sif.ir_i = INSN_ILL; sif.run_i = 1'b1;
        tick(); check_cycle("ill.fetch", 3'd1, SB_FETCHL);
        tick(); check_cycle("ill.decode", 3'd2, SB_NONE);
        check("ill.decode.fault", 32'(sif.fault_o), 32'd0);
        tick(); check_cycle("ill.halt", 3'd6, SB_NONE);
        check("ill.fault", 32'(sif.fault_o), 32'd1);
        tick(); tick(); check_cycle("ill.halt_hold", 3'd6, SB_NONE);
        check("ill.fault_hold", 32'(sif.fault_o), 32'd1);
        check("ill.retired", sif.retired_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
